// File: rtl/instr_mem_loader.sv
// -----------------------------------------------------------------------------
// instr_mem_loader
//   Synchronous instruction memory (2**ADDR_W x DATA_W) with a word-by-word
//   program loader and a one-cycle, stall-aware fetch port.
//
//   Optional feature macro: IMEM_BOOT_CLEAR_EN
//     defined   - reset enters CLEAR and fills every word with NOP_WORD
//     undefined - reset goes straight to IDLE, memory keeps its contents
//
//   Ports
//     clk          single clock, posedge
//     rst          synchronous active-high reset
//     fetch_req    fetch request from the core (honoured only in RUN)
//     pc_in        fetch address, sampled with fetch_req
//     stall        holds data_out / data_valid
//     data_out     registered fetched instruction
//     data_valid   data_out holds a fresh fetch result
//     load_start   pulse; (re)starts loading at address 0
//     load_valid   load_data is valid this cycle
//     load_data    word to write
//     load_last    marks the final word (qualified by load_valid)
//     load_done    one-cycle pulse after the final load write
//     busy         high in CLEAR and LOAD
//     ready        high in RUN
// -----------------------------------------------------------------------------
module instr_mem_loader #(
  parameter int unsigned       DATA_W   = 16,
  parameter int unsigned       ADDR_W   = 6,
  parameter logic [DATA_W-1:0] NOP_WORD = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              stall,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_done,
  output logic              busy,
  output logic              ready
);

  // state    | meaning
  // ST_CLEAR | boot clear: write NOP_WORD to every address, one per cycle
  // ST_IDLE  | no program present; fetches ignored
  // ST_LOAD  | host writes words at load_addr, one per load_valid
  // ST_RUN   | program present; fetches honoured
  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_LOAD  = 2'd2,
    ST_RUN   = 2'd3
  } state_e;

  localparam int unsigned DEPTH = 2 ** ADDR_W;

`ifdef IMEM_BOOT_CLEAR_EN
  localparam state_e RESET_STATE = ST_CLEAR;
`else
  localparam state_e RESET_STATE = ST_IDLE;
`endif

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   load_addr_q, load_addr_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic                data_valid_q, data_valid_d;
  logic                load_done_q, load_done_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  logic                addr_last;

  // load_addr doubles as the clear pointer, so the same terminal compare ends
  // both the clear sweep and a load that fills the whole memory.
  assign addr_last = (load_addr_q == {ADDR_W{1'b1}});

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RESET_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
`ifdef IMEM_BOOT_CLEAR_EN
      ST_CLEAR: begin
        // load_start deliberately ignored until the sweep finishes
        if (addr_last) state_d = ST_IDLE;
      end
`endif
      ST_IDLE: begin
        if (load_start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (load_start) begin
          state_d = ST_LOAD;
        end else if (load_valid && (load_last || addr_last)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (load_start) state_d = ST_LOAD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    busy         = 1'b0;
    ready        = 1'b0;
    load_addr_d  = load_addr_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    load_done_d  = 1'b0;
    mem_we       = 1'b0;
    mem_waddr    = load_addr_q;
    mem_wdata    = (state_q == ST_CLEAR) ? NOP_WORD : load_data;

    case (state_q)
`ifdef IMEM_BOOT_CLEAR_EN
      ST_CLEAR: begin
        busy        = 1'b1;
        mem_we      = 1'b1;
        load_addr_d = load_addr_q + ADDR_W'(1);  // wraps to 0 for the load
      end
`endif
      ST_IDLE: begin
        if (load_start) load_addr_d = '0;
      end
      ST_LOAD: begin
        busy = 1'b1;
        // A restart takes priority and drops a coincident write.
        if (load_start) begin
          load_addr_d = '0;
        end else if (load_valid) begin
          mem_we      = 1'b1;
          load_addr_d = load_addr_q + ADDR_W'(1);
          load_done_d = load_last || addr_last;
        end
      end
      ST_RUN: begin
        ready = 1'b1;
        if (load_start) begin
          load_addr_d = '0;
        end else if (stall) begin
          data_valid_d = data_valid_q;
        end else if (fetch_req) begin
          data_out_d   = mem_q[pc_in];
          data_valid_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      load_addr_q  <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      load_done_q  <= 1'b0;
    end else begin
      load_addr_q  <= load_addr_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      load_done_q  <= load_done_d;
    end
  end

  // Storage has no reset; rst only blocks writes so it overrides a
  // coincident load_valid.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign load_done  = load_done_q;

endmodule
